axi_mm2s_responder: RTL and testbench
=====================================

# axi_mm2s_responder

Synthesizable AXI4 read-channel responder backed by an on-chip word RAM. It is the subordinate end of the read bursts issued by the accelerator's `m_axi_mm2s_*` DMA masters (weights, pixels, partial sums), and lets `top` be exercised on FPGA/emulation without the behavioural memory model. A simple preload port fills the RAM before a run. It handles one outstanding burst at a time and sustains one beat per cycle under full `rready`.

## Interface
- `AXI_WIDTH`, 128, data width in bits (power of 2, ≥32)
- `AXI_ID_WIDTH`, 6, ID width
- `AXI_ADDR_WIDTH`, 32, byte-address width
- `DEPTH`, 1024, RAM depth in AXI_WIDTH words
- `LSB`, $clog2(AXI_WIDTH)-3, derived byte-offset bits; not overridden

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `rstn` in 1 — asynchronous, active-low reset
- `s_axi_arid` in AXI_ID_WIDTH; `s_axi_araddr` in AXI_ADDR_WIDTH; `s_axi_arlen` in 8; `s_axi_arsize` in 3; `s_axi_arburst` in 2; `s_axi_arlock` in 1, `s_axi_arcache` in 4, `s_axi_arprot` in 3 (all three ignored)
- `s_axi_arvalid` in 1; `s_axi_arready` out 1
- `s_axi_rid` out AXI_ID_WIDTH; `s_axi_rdata` out AXI_WIDTH; `s_axi_rresp` out 2; `s_axi_rlast` out 1; `s_axi_rvalid` out 1; `s_axi_rready` in 1
- `pl_en` in 1, `pl_addr` in $clog2(DEPTH) (word index), `pl_data` in AXI_WIDTH, `pl_strb` in AXI_WIDTH/8 — preload write port, byte-strobed

## Operation
- FSM states: IDLE, BURST.
- IDLE: `arready`=1. On `arvalid&&arready`, capture id, addr, len, size, burst; go to BURST.
- BURST: `arready`=0. Beat counter runs 0..arlen. After each RAM read issue, the address advances as follows:
  - INCR: address += 1<<arsize.
  - FIXED: address held.
  - WRAP (2'b10) or reserved (2'b11): every beat gets `rresp`=SLVERR (2'b10) and `rdata`=0; arlen+1 beats are still returned.
- Word index = addr[LSB+:$clog2(DEPTH)]. If addr>>LSB ≥ DEPTH, that beat gets SLVERR with `rdata`=0; other beats of the same burst get OKAY.
- Narrow transfers (arsize < LSB): the full word containing the addressed lanes is returned; no lane masking.
- `rid`=captured arid on every beat. `rlast`=1 only on beat arlen.
- Return to IDLE on the cycle of the `rlast` handshake.
- RAM: synchronous read with 1-cycle latency. A 2-entry output skid buffer absorbs in-flight reads when `rready` drops. Read issue stalls whenever the issued-but-unconsumed beat count would exceed 2.
- Preload: the write lands at the clock edge when `pl_en`=1. For a same-cycle read and preload of the same word, the read returns the old data (read-first). Preload during BURST is legal.
- 4 KB boundary crossing is not checked. Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH.

## Timing
- Reset values: `arready`=0 while `rstn`=0 and 1 in the first cycle after release (IDLE). `rvalid`, `rlast`, `rresp`, `rid`, `rdata` are all 0.
- Reset asserted mid-burst: the burst is abandoned and the skid buffer is emptied. RAM contents are not reset.
- Latency: AR handshake at edge T → first `rvalid` at T+2.
- With `rready` held high, beats are back-to-back, so a len-N burst completes at T+2+N.
- `arready` rises the cycle after the `rlast` handshake, so the minimum AR-to-AR spacing is arlen+3 cycles.
- While `rvalid&&!rready`, `rdata`, `rresp`, `rlast` and `rid` hold stable. `rvalid` never drops without a handshake.
- After `rready` rises following a stall, beats resume back-to-back with no bubble.
- All outputs are registered; no combinational path from AR/R inputs to outputs.

## Test plan
- Preload words 0..7 with value i*0x0101…; AR addr 0x0, len 7, size 4, INCR, `rready`=1 → 8 consecutive beats carrying words 0..7, first `rvalid` at T+2, `rlast` on beat 8, rresp=OKAY, `rid`=arid=0x2A.
- Same burst with `rready` random at 50% → identical data order; outputs stable during stalls; no beat lost or duplicated.
- FIXED burst, addr 0x20, len 3 → 4 beats, all word 2, `rlast` on beat 4.
- DEPTH=1024, INCR addr 0x3FF0, len 1 → beat 0 OKAY with word 1023; beat 1 SLVERR with `rdata`=0.
- WRAP burst len 3 → 4 beats SLVERR with data 0. A second AR presented during the burst is held off (`arready`=0) and accepted the cycle after `rlast`.
- Reset pulsed at beat 3 of a len-15 burst → `rvalid`=0 immediately. After release, `arready`=1 and a new burst returns the preloaded data intact.

Source files
------------

// File: rtl/axi_mm2s_responder_if.sv
// ---------------------------------------------------------------------------
// axi_mm2s_responder_if
//
// Purpose: groups the AXI4 read address (AR) and read data (R) channels
// between a DMA read master and the axi_mm2s_responder RAM subordinate.
//
// Signals (AXI4 names):
//   AR: s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
//       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid, s_axi_arready
//   R : s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
//       s_axi_rready
//
// Handshake: a transfer on a channel happens at a rising clock edge where
// both valid and ready are high. Once valid is raised, the sender holds it
// and every payload signal stable until that edge; ready may toggle freely
// and never depends on valid being low.
//
// Modports: master drives AR payload/valid and rready; slave drives arready
// and the R payload/valid.
// ---------------------------------------------------------------------------
interface axi_mm2s_responder_if #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ID_WIDTH-1:0]   s_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]                s_axi_arlen;
    logic [2:0]                s_axi_arsize;
    logic [1:0]                s_axi_arburst;
    logic                      s_axi_arlock;
    logic [3:0]                s_axi_arcache;
    logic [2:0]                s_axi_arprot;
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;

    logic [AXI_ID_WIDTH-1:0]   s_axi_rid;
    logic [AXI_WIDTH-1:0]      s_axi_rdata;
    logic [1:0]                s_axi_rresp;
    logic                      s_axi_rlast;
    logic                      s_axi_rvalid;
    logic                      s_axi_rready;

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid,
               s_axi_rready,
        input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid
    );

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arvalid,
               s_axi_rready,
        output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
               s_axi_rvalid
    );
endinterface

// File: rtl/axi_mm2s_responder.sv
// ---------------------------------------------------------------------------
// axi_mm2s_responder
//
// Purpose: AXI4 read-channel subordinate backed by an on-chip word RAM, used
// in place of a behavioural memory model so the accelerator's mm2s DMA
// masters can run on FPGA/emulation. One outstanding burst at a time, one
// beat per cycle under continuous rready. A byte-strobed preload port fills
// the RAM before (or during) a run.
//
// Ports:
//   clk, rstn          single clock (rising edge), asynchronous active-low reset
//   bus (slave)        AXI4 AR and R channels (see axi_mm2s_responder_if)
//   pl_en/pl_addr      preload write enable and word index
//   pl_data/pl_strb    preload data and byte strobes
//   dbg_state_o        current FSM state (0 = IDLE, 1 = BURST)
//
// Burst handling: INCR advances by 1<<arsize bytes per beat, FIXED holds the
// address, WRAP and the reserved encoding answer every beat with SLVERR and
// zero data. Beats whose word index falls outside the RAM get SLVERR/zero.
// Narrow transfers return the whole containing word.
// ---------------------------------------------------------------------------
module axi_mm2s_responder #(
    parameter int  AXI_WIDTH      = 128,
    parameter int  AXI_ID_WIDTH   = 6,
    parameter int  AXI_ADDR_WIDTH = 32,
    parameter int  DEPTH          = 1024,
    parameter int  LSB            = $clog2(AXI_WIDTH) - 3,
    localparam int IDXW           = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    axi_mm2s_responder_if.slave    bus,
    input  logic                   pl_en,
    input  logic [IDXW-1:0]        pl_addr,
    input  logic [AXI_WIDTH-1:0]   pl_data,
    input  logic [AXI_WIDTH/8-1:0] pl_strb,
    output logic                   dbg_state_o
);
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    typedef struct packed {
        logic                 last;
        logic [1:0]           resp;
        logic [AXI_WIDTH-1:0] data;
    } beat_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    logic [AXI_WIDTH-1:0] mem [DEPTH];

    state_t                    state_q;
    logic                      arready_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [7:0]                beat_q;
    logic                      iss_done_q;

    // Two-entry output skid buffer: head drives the R channel, tail holds the
    // read that was already in flight when rready dropped.
    logic  h_vld_q, t_vld_q;
    beat_t h_q, t_q;

    logic                      pop;
    logic                      issue;
    logic [AXI_ADDR_WIDTH-1:0] word_addr;
    logic [IDXW-1:0]           idx;
    logic                      rd_err;
    beat_t                     rd_beat;
    logic                      unused_ok;

    always_comb begin
        pop       = h_vld_q && bus.s_axi_rready;
        // Issue only if the buffer can take one more beat after this cycle's
        // pop, so issued-but-unconsumed beats never exceed two.
        issue     = (state_q == BURST) && !iss_done_q && (!t_vld_q || pop);
        word_addr = addr_q >> LSB;
        idx       = addr_q[LSB +: IDXW];
        rd_err    = burst_q[1] || (word_addr >= AXI_ADDR_WIDTH'(DEPTH));
        rd_beat.last = (beat_q == len_q);
        rd_beat.resp = rd_err ? RESP_SLVERR : RESP_OKAY;
        // Synchronous read: the RAM word is sampled into the skid buffer at
        // the issue edge.
        rd_beat.data = rd_err ? '0 : mem[idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            iss_done_q <= 1'b0;
            h_vld_q    <= 1'b0;
            t_vld_q    <= 1'b0;
            h_q        <= '0;
            t_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (bus.s_axi_arvalid && arready_q) begin
                        id_q       <= bus.s_axi_arid;
                        addr_q     <= bus.s_axi_araddr;
                        len_q      <= bus.s_axi_arlen;
                        size_q     <= bus.s_axi_arsize;
                        burst_q    <= bus.s_axi_arburst;
                        beat_q     <= '0;
                        iss_done_q <= 1'b0;
                        arready_q  <= 1'b0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        beat_q <= beat_q + 8'd1;
                        if (rd_beat.last) begin
                            iss_done_q <= 1'b1;
                        end
                        if (burst_q == BURST_INCR) begin
                            addr_q <= addr_q + (AXI_ADDR_WIDTH'(1) << size_q);
                        end
                    end
                    if (pop && h_q.last) begin
                        state_q   <= IDLE;
                        arready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            unique case ({issue, pop})
                2'b10: begin
                    if (!h_vld_q) begin
                        h_vld_q <= 1'b1;
                        h_q     <= rd_beat;
                    end else begin
                        t_vld_q <= 1'b1;
                        t_q     <= rd_beat;
                    end
                end
                2'b01: begin
                    h_vld_q <= t_vld_q;
                    if (t_vld_q) begin
                        h_q <= t_q;
                    end
                    t_vld_q <= 1'b0;
                end
                2'b11: begin
                    if (t_vld_q) begin
                        h_q <= t_q;
                        t_q <= rd_beat;
                    end else begin
                        h_q <= rd_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    // Preload port; RAM contents survive reset. Reads in the same cycle see
    // the old word because the write lands at the clock edge.
    always_ff @(posedge clk) begin
        if (pl_en) begin
            for (int b = 0; b < AXI_WIDTH / 8; b++) begin
                if (pl_strb[b]) begin
                    mem[pl_addr][b*8 +: 8] <= pl_data[b*8 +: 8];
                end
            end
        end
    end

    assign bus.s_axi_arready = arready_q;
    assign bus.s_axi_rvalid  = h_vld_q;
    assign bus.s_axi_rdata   = h_q.data;
    assign bus.s_axi_rresp   = h_q.resp;
    assign bus.s_axi_rlast   = h_q.last;
    assign bus.s_axi_rid     = id_q;
    assign dbg_state_o       = state_q;

    // Lock, cache and protection attributes have no meaning for this RAM.
    assign unused_ok = ^{bus.s_axi_arlock, bus.s_axi_arcache, bus.s_axi_arprot};
endmodule

// File: tb/tb_axi_mm2s_responder.sv
module tb_axi_mm2s_responder;
    localparam int W     = 128;
    localparam int IDW   = 6;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int IDXW  = 10;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_mm2s_responder_if #(.AXI_WIDTH(W), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW)) bus ();

    logic            pl_en;
    logic [IDXW-1:0] pl_addr;
    logic [W-1:0]    pl_data;
    logic [W/8-1:0]  pl_strb;
    logic            dbg_state;

    axi_mm2s_responder #(
        .AXI_WIDTH(W), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .pl_en      (pl_en),
        .pl_addr    (pl_addr),
        .pl_data    (pl_data),
        .pl_strb    (pl_strb),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [W-1:0] exp_q[$];

    logic [W-1:0]   cap_data [64];
    logic [1:0]     cap_resp [64];
    logic           cap_last [64];
    logic [IDW-1:0] cap_id   [64];
    int             cap_cyc  [64];
    int             stab_err;
    int             arready_hi;

    localparam logic [W-1:0] W1023 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

    function automatic logic [W-1:0] word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {16{b}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic preload(input int idx, input logic [W-1:0] d, input logic [W/8-1:0] s);
        pl_en   = 1'b1;
        pl_addr = IDXW'(idx);
        pl_data = d;
        pl_strb = s;
        step();
        pl_en   = 1'b0;
    endtask

    // Presents one AR; returns the cycle number just after the accepting edge.
    task automatic do_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         output int hs_cyc, output bit timeout);
        bus.s_axi_arid    = id;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = len;
        bus.s_axi_arsize  = size;
        bus.s_axi_arburst = burst;
        bus.s_axi_arvalid = 1'b1;
        timeout = 1'b1;
        hs_cyc  = -1;
        for (int k = 0; k < 50; k++) begin
            if (bus.s_axi_arready) begin
                step();
                hs_cyc  = cyc;
                timeout = 1'b0;
                break;
            end
            step();
        end
        bus.s_axi_arvalid = 1'b0;
    endtask

    // Collects up to n beats with rready asserted pct% of cycles. Records
    // each beat and counts stability violations during stalls.
    task automatic collect(input int n, input int pct, output int got);
        logic [W-1:0]   s_data;
        logic [1:0]     s_resp;
        logic           s_last;
        logic [IDW-1:0] s_id;
        bit             stalled;
        bit             rr;
        got        = 0;
        stab_err   = 0;
        arready_hi = 0;
        stalled    = 1'b0;
        for (int g = 0; g < 400 && got < n; g++) begin
            rr = ($urandom_range(99) < pct);
            bus.s_axi_rready = rr;
            if (bus.s_axi_arready) arready_hi++;
            if (bus.s_axi_rvalid) begin
                if (stalled && (bus.s_axi_rdata !== s_data || bus.s_axi_rresp !== s_resp ||
                                bus.s_axi_rlast !== s_last || bus.s_axi_rid !== s_id))
                    stab_err++;
                if (rr) begin
                    cap_data[got] = bus.s_axi_rdata;
                    cap_resp[got] = bus.s_axi_rresp;
                    cap_last[got] = bus.s_axi_rlast;
                    cap_id[got]   = bus.s_axi_rid;
                    cap_cyc[got]  = cyc;
                    got++;
                    stalled = 1'b0;
                end else begin
                    s_data  = bus.s_axi_rdata;
                    s_resp  = bus.s_axi_rresp;
                    s_last  = bus.s_axi_rlast;
                    s_id    = bus.s_axi_rid;
                    stalled = 1'b1;
                end
            end else if (stalled) begin
                stab_err++;
            end
            step();
        end
        bus.s_axi_rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        n_cmp++; if (bus.s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b want 0", bus.s_axi_arready); end
        n_cmp++; if (bus.s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.s_axi_rvalid); end
        n_cmp++; if ({bus.s_axi_rlast, bus.s_axi_rresp, bus.s_axi_rid} !== 9'd0) begin n_fail++; $display("FAIL reset_rlast_rresp_rid: got %h want 0", {bus.s_axi_rlast, bus.s_axi_rresp, bus.s_axi_rid}); end
        n_cmp++; if (bus.s_axi_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.s_axi_rdata); end
        rstn = 1'b1;
        step();
        n_cmp++; if (bus.s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL reset_release_arready: got %b want 1", bus.s_axi_arready); end
        n_cmp++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", dbg_state); end
    endtask

    task automatic test_incr_basic();
        int t, got;
        bit to;
        do_ar(6'h2A, 32'h0, 8'd7, 3'd4, 2'b01, t, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL incr_ar_accept: timeout=%b want 0", to); end
        n_cmp++; if (bus.s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL incr_rvalid_early: got %b want 0", bus.s_axi_rvalid); end
        collect(8, 100, got);
        n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL incr_beats: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++; if (cap_data[i] !== word(i)) begin n_fail++; $display("FAIL incr_data[%0d]: got %h want %h", i, cap_data[i], word(i)); end
            n_cmp++; if (cap_resp[i] !== 2'b00) begin n_fail++; $display("FAIL incr_resp[%0d]: got %b want 00", i, cap_resp[i]); end
            n_cmp++; if (cap_last[i] !== (i == 7)) begin n_fail++; $display("FAIL incr_last[%0d]: got %b want %b", i, cap_last[i], (i == 7)); end
            n_cmp++; if (cap_id[i] !== 6'h2A) begin n_fail++; $display("FAIL incr_rid[%0d]: got %h want 2a", i, cap_id[i]); end
            // rvalid visible after edge T+1, so beat i handshakes at edge T+2+i.
            n_cmp++; if (cap_cyc[i] !== t + 1 + i) begin n_fail++; $display("FAIL incr_timing[%0d]: got cycle %0d want %0d", i, cap_cyc[i], t + 1 + i); end
        end
        n_cmp++; if (bus.s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL incr_arready_after: got %b want 1", bus.s_axi_arready); end
    endtask

    task automatic test_random_rready();
        int t, got;
        bit to;
        logic [W-1:0] e;
        for (int i = 0; i < 8; i++) exp_q.push_back(word(i));
        do_ar(6'h2A, 32'h0, 8'd7, 3'd4, 2'b01, t, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_ar_accept: timeout=%b want 0", to); end
        collect(8, 50, got);
        n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL rand_beats: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            e = exp_q.pop_front();
            n_cmp++; if (cap_data[i] !== e) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, cap_data[i], e); end
            n_cmp++; if (cap_last[i] !== (i == 7)) begin n_fail++; $display("FAIL rand_last[%0d]: got %b want %b", i, cap_last[i], (i == 7)); end
        end
        exp_q.delete();
        n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d violations want 0", stab_err); end
        // No extra beat may appear after rlast.
        step();
        n_cmp++; if (bus.s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rand_no_extra: got rvalid %b want 0", bus.s_axi_rvalid); end
    endtask

    task automatic test_fixed();
        int t, got;
        bit to;
        do_ar(6'h05, 32'h20, 8'd3, 3'd4, 2'b00, t, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL fixed_ar_accept: timeout=%b want 0", to); end
        collect(4, 100, got);
        n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL fixed_beats: got %0d want 4", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++; if (cap_data[i] !== word(2)) begin n_fail++; $display("FAIL fixed_data[%0d]: got %h want %h", i, cap_data[i], word(2)); end
            n_cmp++; if (cap_last[i] !== (i == 3)) begin n_fail++; $display("FAIL fixed_last[%0d]: got %b want %b", i, cap_last[i], (i == 3)); end
        end
    endtask

    task automatic test_oob();
        int t, got;
        bit to;
        do_ar(6'h07, 32'h3FF0, 8'd1, 3'd4, 2'b01, t, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL oob_ar_accept: timeout=%b want 0", to); end
        collect(2, 100, got);
        n_cmp++; if (got !== 2) begin n_fail++; $display("FAIL oob_beats: got %0d want 2", got); end
        n_cmp++; if (cap_resp[0] !== 2'b00) begin n_fail++; $display("FAIL oob_resp0: got %b want 00", cap_resp[0]); end
        n_cmp++; if (cap_data[0] !== W1023) begin n_fail++; $display("FAIL oob_data0: got %h want %h", cap_data[0], W1023); end
        n_cmp++; if (cap_resp[1] !== 2'b10) begin n_fail++; $display("FAIL oob_resp1: got %b want 10", cap_resp[1]); end
        n_cmp++; if (cap_data[1] !== '0) begin n_fail++; $display("FAIL oob_data1: got %h want 0", cap_data[1]); end
        n_cmp++; if (cap_last[1] !== 1'b1) begin n_fail++; $display("FAIL oob_last1: got %b want 1", cap_last[1]); end
    endtask

    task automatic test_wrap_back_to_back();
        int t1, t2, got;
        bit to;
        do_ar(6'h33, 32'h40, 8'd3, 3'd4, 2'b10, t1, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_ar_accept: timeout=%b want 0", to); end
        // Second AR waits while the WRAP burst is in progress.
        bus.s_axi_arid    = 6'h11;
        bus.s_axi_araddr  = 32'h0;
        bus.s_axi_arlen   = 8'd0;
        bus.s_axi_arsize  = 3'd4;
        bus.s_axi_arburst = 2'b01;
        bus.s_axi_arvalid = 1'b1;
        collect(4, 100, got);
        n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL wrap_beats: got %0d want 4", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++; if ({cap_resp[i], cap_data[i]} !== {2'b10, {W{1'b0}}}) begin n_fail++; $display("FAIL wrap_beat[%0d]: got resp %b data %h want resp 10 data 0", i, cap_resp[i], cap_data[i]); end
        end
        n_cmp++; if (cap_last[3] !== 1'b1) begin n_fail++; $display("FAIL wrap_last: got %b want 1", cap_last[3]); end
        n_cmp++; if (arready_hi !== 0) begin n_fail++; $display("FAIL wrap_holdoff: arready high %0d cycles want 0", arready_hi); end
        n_cmp++; if (bus.s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL wrap_arready_after_rlast: got %b want 1", bus.s_axi_arready); end
        step();
        t2 = cyc;
        bus.s_axi_arvalid = 1'b0;
        n_cmp++; if (t2 - t1 !== 3 + 3) begin n_fail++; $display("FAIL ar_spacing: got %0d want 6", t2 - t1); end
        collect(1, 100, got);
        n_cmp++; if (got !== 1) begin n_fail++; $display("FAIL second_beats: got %0d want 1", got); end
        n_cmp++; if ({cap_id[0], cap_resp[0], cap_last[0]} !== {6'h11, 2'b00, 1'b1}) begin n_fail++; $display("FAIL second_ctrl: got id %h resp %b last %b want 11/00/1", cap_id[0], cap_resp[0], cap_last[0]); end
        n_cmp++; if (cap_data[0] !== word(0)) begin n_fail++; $display("FAIL second_data: got %h want %h", cap_data[0], word(0)); end
    endtask

    task automatic test_read_first();
        int t;
        bit to;
        logic [W-1:0] new_w;
        new_w = 128'h0505_0505_0505_0505_0505_0505_0505_FFFF;
        bus.s_axi_rready = 1'b1;
        do_ar(6'h01, 32'h50, 8'd2, 3'd4, 2'b00, t, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rf_ar_accept: timeout=%b want 0", to); end
        step();
        n_cmp++; if ({bus.s_axi_rvalid, bus.s_axi_rdata} !== {1'b1, word(5)}) begin n_fail++; $display("FAIL rf_beat0: got v %b data %h want 1 %h", bus.s_axi_rvalid, bus.s_axi_rdata, word(5)); end
        // Preload word 5 in the same cycle that beat 1 reads it.
        pl_en   = 1'b1;
        pl_addr = IDXW'(5);
        pl_data = {W{1'b1}};
        pl_strb = 16'h0003;
        step();
        pl_en = 1'b0;
        n_cmp++; if (bus.s_axi_rdata !== word(5)) begin n_fail++; $display("FAIL rf_beat1_old: got %h want %h", bus.s_axi_rdata, word(5)); end
        step();
        n_cmp++; if (bus.s_axi_rdata !== new_w) begin n_fail++; $display("FAIL rf_beat2_new: got %h want %h", bus.s_axi_rdata, new_w); end
        n_cmp++; if (bus.s_axi_rlast !== 1'b1) begin n_fail++; $display("FAIL rf_last: got %b want 1", bus.s_axi_rlast); end
        step();
        bus.s_axi_rready = 1'b0;
        n_cmp++; if (bus.s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rf_done: got rvalid %b want 0", bus.s_axi_rvalid); end
    endtask

    task automatic test_reset_midburst();
        int t, got;
        bit to;
        do_ar(6'h3C, 32'h0, 8'd15, 3'd4, 2'b01, t, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rst_ar_accept: timeout=%b want 0", to); end
        collect(3, 100, got);
        n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL rst_beats_before: got %0d want 3", got); end
        n_cmp++; if (bus.s_axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL rst_beat3_valid: got %b want 1", bus.s_axi_rvalid); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid_async: got %b want 0", bus.s_axi_rvalid); end
        n_cmp++; if (bus.s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready_low: got %b want 0", bus.s_axi_arready); end
        step();
        rstn = 1'b1;
        step();
        n_cmp++; if (bus.s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rst_arready_release: got %b want 1", bus.s_axi_arready); end
        n_cmp++; if (bus.s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_skid_empty: got %b want 0", bus.s_axi_rvalid); end
        do_ar(6'h0F, 32'h0, 8'd7, 3'd4, 2'b01, t, to);
        collect(8, 100, got);
        n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL rst_after_beats: got %0d want 8", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++; if (cap_data[i] !== word(i)) begin n_fail++; $display("FAIL rst_after_data[%0d]: got %h want %h", i, cap_data[i], word(i)); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.s_axi_arid    = '0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arlen   = '0;
        bus.s_axi_arsize  = '0;
        bus.s_axi_arburst = '0;
        bus.s_axi_arlock  = 1'b0;
        bus.s_axi_arcache = '0;
        bus.s_axi_arprot  = '0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b0;
        pl_en   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        pl_strb = '0;
        #1;

        test_reset();
        for (int i = 0; i < 16; i++) preload(i, word(i), '1);
        preload(1023, W1023, '1);
        test_incr_basic();
        test_random_rready();
        test_fixed();
        test_oob();
        test_wrap_back_to_back();
        test_read_first();
        preload(5, word(5), '1);
        test_reset_midburst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
